// File: rtl/pine_pkg.sv
// Shared constants for the payload gathering scheduler:
// FSM state codes, index widths and header byte layout.
package pine_pkg;

  localparam int NBLOCK_DEF = 24;
  localparam int IDX_W      = 5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_HDR  = 3'd3;
  localparam logic [2:0] ST_BODY = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam int HDR_OFLOW_BIT = 7;
  localparam int HDR_IDX_W     = 5;

  function automatic logic [7:0] hdr_byte(
    input logic             oflow,
    input logic [IDX_W-1:0] idx
  );
    logic [7:0] h;
    h                  = '0;
    h[HDR_OFLOW_BIT]   = oflow;
    h[HDR_IDX_W-1:0]   = idx[HDR_IDX_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/fifo_sched_rr_ptr.sv
// Round-robin successor of a block index, wrapping NBLOCK -> 1.
// Out-of-range inputs (0 or > NBLOCK) restart at block 1.
module rr_ptr
  import pine_pkg::*;
#(
  parameter int NBLOCK = NBLOCK_DEF
) (
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_next
);

  logic w_wrap;

  assign w_wrap = (i_last_grant == '0) ||
                  (i_last_grant >= IDX_W'(NBLOCK));

  assign o_next = w_wrap ? IDX_W'(1)
                         : i_last_grant + IDX_W'(1);

endmodule

// File: rtl/fifo_sched.sv
// Gathers one frame of records from the hashing-block FIFOs:
// round-robin scan, serial word read, header + body bytes out.
module fifo_sched
  import pine_pkg::*;
#(
  parameter int NBLOCK    = NBLOCK_DEF,
  parameter int WORD_BITS = 64,
  parameter int MAX_REC   = 16
) (
  input  logic              mii_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NBLOCK-1:0] fifo_empty,
  input  logic [NBLOCK-1:0] fifo_oflow,
  input  logic [NBLOCK-1:0] fifo_bits,
  output logic [NBLOCK-1:0] fifo_req,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rec_count
);

  localparam int CW    = $clog2(WORD_BITS + 1);
  localparam int NBYTE = WORD_BITS / 8;

  logic [2:0]           r_state;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_cand;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_miss;
  logic                 r_oflow;
  logic [CW-1:0]        r_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [4:0]           r_rec;

  logic [IDX_W-1:0]     w_first;
  logic [IDX_W-1:0]     w_next;
  logic [NBLOCK-1:0]    w_cand_oh;
  logic [NBLOCK-1:0]    w_grant_oh;
  logic                 w_cand_empty;
  logic                 w_cand_oflow;
  logic                 w_bit;
  logic                 w_accept;

  rr_ptr #(.NBLOCK(NBLOCK)) u_rr_first (
    .i_last_grant (r_last),
    .o_next       (w_first)
  );

  rr_ptr #(.NBLOCK(NBLOCK)) u_rr_scan (
    .i_last_grant (r_cand),
    .o_next       (w_next)
  );

  assign w_cand_oh    = NBLOCK'(1) << (r_cand - IDX_W'(1));
  assign w_grant_oh   = NBLOCK'(1) << (r_grant - IDX_W'(1));
  assign w_cand_empty = |(fifo_empty & w_cand_oh);
  assign w_cand_oflow = |(fifo_oflow & w_cand_oh);
  assign w_bit        = |(fifo_bits & w_grant_oh);

  assign fifo_req  = (r_state == ST_READ && r_cnt < CW'(WORD_BITS))
                     ? w_grant_oh : '0;
  assign out_valid = (r_state == ST_HDR) || (r_state == ST_BODY);
  assign out_data  = (r_state == ST_HDR)  ? hdr_byte(r_oflow, r_grant) :
                     (r_state == ST_BODY) ? r_shift[WORD_BITS-1 -: 8] :
                     8'h00;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign rec_count = r_rec;
  assign w_accept  = out_valid & out_ready;

  // Frame sequencer: scan, serial read, header, body, repeat.
  always_ff @(posedge mii_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= IDX_W'(NBLOCK);
      r_cand  <= '0;
      r_grant <= '0;
      r_miss  <= '0;
      r_oflow <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_rec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_rec   <= '0;
            r_cand  <= w_first;
            r_miss  <= '0;
          end
        end
        ST_SCAN: begin
          if (r_rec == 5'(MAX_REC)) begin
            r_state <= ST_DONE;
          end else if (!w_cand_empty) begin
            r_state <= ST_READ;
            r_grant <= r_cand;
            r_last  <= r_cand;
            r_oflow <= w_cand_oflow;
            r_cnt   <= '0;
          end else if (r_miss == IDX_W'(NBLOCK - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_cand <= w_next;
            r_miss <= r_miss + IDX_W'(1);
          end
        end
        ST_READ: begin
          if (r_cnt != '0) begin
            r_shift <= {r_shift[WORD_BITS-2:0], w_bit};
          end
          if (r_cnt == CW'(WORD_BITS)) begin
            r_state <= ST_HDR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_accept) begin
            r_shift <= r_shift << 8;
            if (r_cnt == CW'(NBYTE - 1)) begin
              r_state <= ST_SCAN;
              r_rec   <= r_rec + 5'd1;
              r_cand  <= w_first;
              r_miss  <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: FIFO models per block, random back-pressure,
// expected byte stream computed from the round-robin rules.
module tb_fifo_sched;

  localparam int NB = 24;
  localparam int WB = 64;
  localparam int MR = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          out_ready = 1'b1;
  logic [NB-1:0] fifo_empty;
  logic [NB-1:0] fifo_oflow;
  logic [NB-1:0] fifo_bits = '0;
  logic [NB-1:0] fifo_req;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [4:0]    rec_count;

  fifo_sched #(
    .NBLOCK    (NB),
    .WORD_BITS (WB),
    .MAX_REC   (MR)
  ) dut (
    .mii_clk    (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_oflow (fifo_oflow),
    .fifo_bits  (fifo_bits),
    .fifo_req   (fifo_req),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .rec_count  (rec_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got_v,
                       input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  // Block FIFOs: words per block, bit-serial MSB-first
  logic [63:0] mem  [1:NB][0:3];
  int          wr_n [1:NB];
  int          rd_i [1:NB];
  int          bp   [1:NB];
  logic        ofl  [1:NB];
  logic        fifo_clr = 1'b0;

  always_comb begin
    fifo_empty = '0;
    fifo_oflow = '0;
    for (int b = 1; b <= NB; b++) begin
      fifo_empty[b-1] = (rd_i[b] >= wr_n[b]);
      fifo_oflow[b-1] = ofl[b];
    end
  end

  always @(posedge clk) begin
    for (int b = 1; b <= NB; b++) begin
      if (fifo_clr) begin
        rd_i[b] <= 0;
        bp[b]   <= 0;
      end else if (fifo_req[b-1]) begin
        fifo_bits[b-1] <= mem[b][rd_i[b] & 3][63 - bp[b]];
        if (bp[b] == 63) begin
          bp[b]   <= 0;
          rd_i[b] <= rd_i[b] + 1;
        end else begin
          bp[b] <= bp[b] + 1;
        end
      end
    end
  end

  // Back-pressure: 0 always ready, 1 random, 2 one cycle in three
  int rdy_mode = 0;
  int ph       = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          ph        = (ph + 1) % 3;
          out_ready = (ph == 0);
        end
      endcase
    end
  end

  // Output monitor
  logic [7:0] got [$];
  int         req_cyc    = 0;
  int         req_bad    = 0;
  int         hold_err   = 0;
  int         valid_cyc  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst_n && prev_stall && (!out_valid || out_data !== prev_data))
      hold_err++;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) got.push_back(out_data);
    if (fifo_req != '0) req_cyc++;
    if ($countones(fifo_req) > 1) req_bad++;
    if (out_valid) valid_cyc++;
  end

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Reference model state
  int         m_last = NB;
  int         m_head [1:NB];
  logic [7:0] exp_q [$];

  task automatic model_frame(output int recs);
    int         cand;
    int         miss;
    logic [4:0] c5;
    logic [63:0] w;
    exp_q.delete();
    recs = 0;
    miss = 0;
    cand = m_last % NB + 1;
    while (recs < MR && miss < NB) begin
      if (m_head[cand] < wr_n[cand]) begin
        c5 = 5'(cand);
        w  = mem[cand][m_head[cand]];
        exp_q.push_back({ofl[cand], 2'b00, c5});
        for (int k = 7; k >= 0; k--) exp_q.push_back(w[k*8 +: 8]);
        m_head[cand]++;
        recs++;
        m_last = cand;
        miss   = 0;
      end else begin
        miss++;
      end
      cand = cand % NB + 1;
    end
  endtask

  task automatic clear_fifos();
    for (int b = 1; b <= NB; b++) begin
      wr_n[b]   = 0;
      ofl[b]    = 1'b0;
      m_head[b] = 0;
    end
    fifo_clr = 1'b1;
    @(posedge clk);
    #1 fifo_clr = 1'b0;
  endtask

  task automatic add_word(input int b, input logic [63:0] w);
    mem[b][wr_n[b]] = w;
    wr_n[b]++;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit extra, output int gb,
                           output int cyc, output int rc);
    int recs, rb, hb, qb;
    model_frame(recs);
    gb = got.size();
    rb = req_cyc;
    hb = hold_err;
    qb = req_bad;
    pulse_start();
    @(negedge clk);
    check("busy_on", busy, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (extra && cyc == 30 && busy) begin
        start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
      end
    end
    rc = rec_count;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("rec_count", rec_count, recs);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("nbytes", got.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("byte", got_at(gb + i), exp_q[i]);
    check("req_cycles", req_cyc - rb, recs * WB);
    check("req_onehot", req_bad - qb, 0);
    check("hold", hold_err - hb, 0);
  endtask

  initial begin
    int gb, cyc, rc, vb, n;
    clear_fifos();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_req", fifo_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rec", rec_count, 0);
    #2 rst_n = 1'b1;
    m_last = NB;

    // single block 5, 0xA5 pattern
    clear_fifos();
    add_word(5, 64'hA5A5_A5A5_A5A5_A5A5);
    run_frame(0, gb, cyc, rc);
    check("b5_hdr", got_at(gb), 8'h05);
    check("b5_body", got_at(gb + 8), 8'hA5);
    check("b5_recs", rc, 1);

    // all empty
    clear_fifos();
    vb = valid_cyc;
    run_frame(0, gb, cyc, rc);
    check("empty_lat", cyc <= NB + 1, 1);
    check("empty_valid", valid_cyc - vb, 0);
    check("empty_recs", rc, 0);

    // last_grant 23, then blocks 3 and 24
    clear_fifos();
    add_word(23, {$urandom, $urandom});
    run_frame(0, gb, cyc, rc);
    clear_fifos();
    add_word(3, {$urandom, $urandom});
    add_word(24, {$urandom, $urandom});
    run_frame(0, gb, cyc, rc);
    check("rr_hdr0", got_at(gb), 8'h18);
    check("rr_hdr1", got_at(gb + 9), 8'h03);

    // all blocks full, MAX_REC cap, next frame resumes at 17
    clear_fifos();
    add_word(24, {$urandom, $urandom});
    run_frame(0, gb, cyc, rc);
    clear_fifos();
    for (int b = 1; b <= NB; b++) add_word(b, {$urandom, $urandom});
    run_frame(0, gb, cyc, rc);
    check("cap_recs", rc, 16);
    check("cap_first", got_at(gb), 8'h01);
    check("cap_last", got_at(gb + 15 * 9), 8'h10);
    run_frame(0, gb, cyc, rc);
    check("resume_hdr", got_at(gb), 8'h11);
    check("resume_recs", rc, 8);

    // overflow flag with slow consumer
    clear_fifos();
    add_word(7, {$urandom, $urandom});
    ofl[7] = 1'b1;
    rdy_mode = 2;
    run_frame(0, gb, cyc, rc);
    check("ofl_hdr", got_at(gb), 8'h87);

    // random frames, leftovers carried into a second frame
    rdy_mode = 1;
    repeat (3) begin
      clear_fifos();
      for (int b = 1; b <= NB; b++) begin
        n = $urandom_range(0, 5);
        if (n > 2) n = 0;
        ofl[b] = 1'($urandom_range(0, 1));
        for (int k = 0; k < n; k++) add_word(b, {$urandom, $urandom});
      end
      run_frame(1, gb, cyc, rc);
      run_frame(0, gb, cyc, rc);
    end

    // reset mid-body, then scan restarts at block 1
    rdy_mode = 2;
    clear_fifos();
    add_word(7, {$urandom, $urandom});
    add_word(12, {$urandom, $urandom});
    gb = got.size();
    pulse_start();
    cyc = 0;
    while (got.size() < gb + 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_body", cyc < 500, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_req", fifo_req, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_rec", rec_count, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_last = NB;
    rdy_mode = 0;
    clear_fifos();
    add_word(1, {$urandom, $urandom});
    add_word(20, {$urandom, $urandom});
    run_frame(0, gb, cyc, rc);
    check("post_rst_hdr", got_at(gb), 8'h01);
    check("post_rst_hdr2", got_at(gb + 9), 8'h14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_sched.md
FIFO_SCHED -- requirements
Module: fifo_sched

Interface
REQ-001 Parameter NBLOCK, default 24, number of hashing blocks; requester indices are 1..NBLOCK.
REQ-002 Parameter WORD_BITS, default 64, bits read per grant; multiple of 8.
REQ-003 Parameter MAX_REC, default 16, maximum records per frame.
REQ-004 mii_clk  in  1  sole clock, RMII 50 MHz domain.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 start  in  1  single-cycle request from frame transmitter to gather one frame's payload.
REQ-007 fifo_empty  in  NBLOCK  per-block FIFO empty flag, bit i-1 is block i.
REQ-008 fifo_oflow  in  NBLOCK  per-block sticky overflow flag.
REQ-009 fifo_bits  in  NBLOCK  per-block serial read data, valid one cycle after the matching fifo_req bit.
REQ-010 fifo_req  out  NBLOCK  per-block read strobe, at most one bit high; one bit shifted out per high cycle.
REQ-011 out_data  out  8  payload byte to frame transmitter.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  transmitter accepts byte when out_valid and out_ready are both high.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  single-cycle pulse at frame end.
REQ-016 rec_count  out  5  records emitted in the frame, valid with done.

Function
REQ-017 States: IDLE, SCAN, READ, HDR, BODY, DONE.
REQ-018 IDLE: start -> SCAN, clear rec_count, busy=1; start outside IDLE is ignored.
REQ-019 SCAN: examines one candidate per cycle, starting at last_grant+1 and wrapping NBLOCK -> 1.
REQ-020 A non-empty candidate is granted and goes to READ; oflow is latched at grant; last_grant is set to the candidate.
REQ-021 When NBLOCK consecutive candidates are empty, or rec_count == MAX_REC, the next state is DONE.
REQ-022 READ: fifo_req[grant] is held high for exactly WORD_BITS consecutive cycles.
REQ-023 READ: fifo_bits[grant] is captured MSB-first into a WORD_BITS shift register with 1-cycle latency; READ lasts WORD_BITS+1 cycles.
REQ-024 HDR: out_data = {oflow_latched, 2'b00, grant index[4:0]}, out_valid=1, held until out_ready.
REQ-025 BODY: emits WORD_BITS/8 bytes, most significant first; each byte is held stable with out_valid until accepted.
REQ-026 After the last BODY byte is accepted, rec_count increments and the FSM returns to SCAN.
REQ-027 DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
REQ-028 out_valid is low in IDLE, SCAN, READ and DONE; fifo_req is zero outside READ.
REQ-029 A FIFO whose empty flag rises mid-READ is still read for the full WORD_BITS; data is taken as-is.
REQ-030 Any back-pressure length on out_ready is tolerated; data, valid and state are held.
REQ-031 Fairness: a block granted in one frame is rescanned only after all other non-empty blocks have been offered in round-robin order; last_grant persists across frames.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, fifo_req=0, out_valid=0, out_data=0, busy=0, done=0, rec_count=0, last_grant=NBLOCK, shift register=0.
REQ-033 Reset mid-READ or mid-BODY abandons the record with no partial output after release; the first scan after release starts at block 1.

Structure
REQ-034 NBLOCK default, the state enum and header bit positions SHALL live in shared package pine_pkg.
REQ-035 Round-robin candidate/wrap logic SHALL be sub-module rr_ptr (input last_grant, output next index).
REQ-036 Target size is 150-300 lines of RTL.

Verification
REQ-037 Only block 5 non-empty, fifo_bits[4] = 0xA5 repeated, start -> fifo_req[4] high 64 cycles; bytes 0x05, then 8x 0xA5; done with rec_count=1.
REQ-038 All empty, start -> done within NBLOCK+2 cycles, rec_count=0, out_valid never high.
REQ-039 Blocks 3 and 24 non-empty, last_grant=23 -> grant order 24 then 3; headers 0x18, 0x03.
REQ-040 All 24 non-empty, MAX_REC=16 -> exactly 16 records (1..16); next frame starts at block 17.
REQ-041 Block 7 oflow=1, out_ready toggled 1-of-3 cycles -> header 0x87, bytes held stable, no loss or duplication.
REQ-042 rst_n pulsed low mid-BODY -> all outputs zero immediately; next start begins scan at block 1.
